// File: rtl/key_event_queue.sv
// Key/encoder event FIFO with an IRQ/ack handshake toward the host MCU.
// Optional typematic auto-repeat is built when KEY_REPEAT_EN is defined.
module key_event_queue #(
  parameter int DEPTH      = 8,
  parameter int IRQ_RETRY  = 1000,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic                       CLK_LOW,
  input  logic                       RST,
  input  logic                       KEY_INT,
  input  logic [7:0]                 KEY_DATA,
  input  logic                       CODE_INT,
  input  logic [7:0]                 CODE_DATA,
  output logic                       EVT_VALID,
  output logic [7:0]                 EVT_DATA,
  input  logic                       EVT_ACK,
  output logic                       EVT_IRQ,
  output logic [$clog2(DEPTH):0]     EVT_COUNT,
  output logic                       OVERFLOW,
  input  logic                       OVF_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(IRQ_RETRY + 1);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_queue: DEPTH must be a power of two in 2..64");
  end
  if (IRQ_RETRY < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_timing
    $error("key_event_queue: IRQ_RETRY, REPEAT_DLY and REPEAT_PER must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_NOTIFY, S_WAIT} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_p1;
  logic [AW:0]   count, count_nx, free, room;
  logic          pop, drop;
  logic          wr0_en, wr1_en;
  logic [7:0]    wr0_data, wr1_data;
  logic [1:0]    n_wr;
  state_t        state, state_nx;
  logic [RW-1:0] retry_cnt;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RCW  = $clog2(RMAX + 1);

  logic           rep_armed, rep_first, rep_due, rep_try, key_stored;
  logic [5:0]     rep_code;
  logic [RCW-1:0] rep_cnt, rep_target;

  assign rep_target = rep_first ? RCW'(REPEAT_DLY - 1) : RCW'(REPEAT_PER - 1);
  assign rep_due    = rep_armed && (rep_cnt == rep_target);
  // A due repeat yields to any external strobe and retries next cycle.
  assign rep_try    = rep_due && !CODE_INT && !KEY_INT;
`endif

  assign pop       = EVT_ACK && (count != '0);
  assign free      = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
  assign wr_ptr_p1 = wr_ptr + AW'(1);

  // Ingress priority: encoder, key, then repeat; each consumes one free slot.
  always_comb begin
    room     = free;
    drop     = 1'b0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = '0;
    wr1_data = '0;
`ifdef KEY_REPEAT_EN
    key_stored = 1'b0;
`endif
    if (CODE_INT) begin
      if (room != '0) begin
        wr0_en   = 1'b1;
        wr0_data = CODE_DATA;
        room     = room - (AW+1)'(1);
      end else begin
        drop = 1'b1;
      end
    end
    if (KEY_INT) begin
      if (room != '0) begin
`ifdef KEY_REPEAT_EN
        key_stored = 1'b1;
`endif
        room = room - (AW+1)'(1);
        if (wr0_en) begin
          wr1_en   = 1'b1;
          wr1_data = KEY_DATA;
        end else begin
          wr0_en   = 1'b1;
          wr0_data = KEY_DATA;
        end
      end else begin
        drop = 1'b1;
      end
    end
`ifdef KEY_REPEAT_EN
    if (rep_try) begin
      if (room != '0) begin
        wr0_en   = 1'b1;
        wr0_data = {2'b11, rep_code};
      end else begin
        drop = 1'b1;
      end
    end
`endif
  end

  assign n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign count_nx = count + (AW+1)'(n_wr) - (AW+1)'(pop);

  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr0_en) mem[wr_ptr]    <= wr0_data;
      if (wr1_en) mem[wr_ptr_p1] <= wr1_data;
      wr_ptr <= wr_ptr + AW'(n_wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count_nx;
      if (drop)         OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
  end

  assign EVT_DATA  = mem[rd_ptr];
  assign EVT_VALID = (count != '0);
  assign EVT_COUNT = count;

`ifdef KEY_REPEAT_EN
  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
      rep_code  <= '0;
      rep_cnt   <= '0;
    end else if (key_stored && KEY_DATA[7:6] == 2'b01) begin
      rep_armed <= 1'b1;
      rep_first <= 1'b1;
      rep_code  <= KEY_DATA[5:0];
      rep_cnt   <= '0;
    end else if (KEY_INT && KEY_DATA[7:6] == 2'b10 && KEY_DATA[5:0] == rep_code) begin
      rep_armed <= 1'b0;
    end else if (rep_due) begin
      // Stored or dropped, the period restarts; a collision holds the count.
      if (rep_try) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end
    end else if (rep_armed) begin
      rep_cnt <= rep_cnt + RCW'(1);
    end
  end
`endif

  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      retry_cnt <= '0;
    end else begin
      state     <= state_nx;
      retry_cnt <= (state == S_WAIT) ? retry_cnt + RW'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (count != '0) state_nx = S_NOTIFY;
      S_NOTIFY: state_nx = S_WAIT;
      S_WAIT: begin
        if (pop)                                state_nx = (count_nx != '0) ? S_NOTIFY : S_IDLE;
        else if (count == '0)                   state_nx = S_IDLE;  // drained by an ack taken during NOTIFY
        else if (retry_cnt == RW'(IRQ_RETRY-1)) state_nx = S_NOTIFY;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  assign EVT_IRQ = (state == S_NOTIFY);

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with a scoreboard queue of expected FIFO entries.
module tb_key_event_queue;

  logic       CLK_LOW = 1'b0;
  logic       RST, KEY_INT, CODE_INT, EVT_ACK, OVF_CLR;
  logic [7:0] KEY_DATA, CODE_DATA;
  logic       EVT_VALID, EVT_IRQ, OVERFLOW;
  logic [7:0] EVT_DATA;
  logic [3:0] EVT_COUNT;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         seen;

  key_event_queue #(.DEPTH(8), .IRQ_RETRY(1000), .REPEAT_DLY(500), .REPEAT_PER(100)) dut (
    .CLK_LOW(CLK_LOW), .RST(RST), .KEY_INT(KEY_INT), .KEY_DATA(KEY_DATA),
    .CODE_INT(CODE_INT), .CODE_DATA(CODE_DATA), .EVT_VALID(EVT_VALID),
    .EVT_DATA(EVT_DATA), .EVT_ACK(EVT_ACK), .EVT_IRQ(EVT_IRQ),
    .EVT_COUNT(EVT_COUNT), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
  );

  always #5 CLK_LOW = ~CLK_LOW;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_LOW);
    #1;
  endtask

  task automatic chk_count(input string tag);
    chk(tag, 32'(EVT_COUNT), 32'(sb.size()));
  endtask

  task automatic key(input logic [7:0] d, input bit stored);
    KEY_INT  = 1'b1;
    KEY_DATA = d;
    if (stored) sb.push_back(d);
    tick();
    KEY_INT  = 1'b0;
  endtask

  task automatic ack_one(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=pop expected=nonempty_scoreboard", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, 32'(EVT_DATA), 32'(exp));
      EVT_ACK = 1'b1;
      tick();
      EVT_ACK = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b0; KEY_INT = 1'b0; CODE_INT = 1'b0; EVT_ACK = 1'b0; OVF_CLR = 1'b0;
    KEY_DATA = '0; CODE_DATA = '0;
    #2;
    chk("rst_valid", 32'(EVT_VALID), 0);
    chk("rst_data",  32'(EVT_DATA),  0);
    chk("rst_irq",   32'(EVT_IRQ),   0);
    chk("rst_count", 32'(EVT_COUNT), 0);
    chk("rst_ovf",   32'(OVERFLOW),  0);
    @(negedge CLK_LOW);
    RST = 1'b1;
    tick();

    // single key event and its IRQ timing
    key(8'h45, 1'b1);
    chk_count("t1_count");
    chk("t1_valid", 32'(EVT_VALID), 1);
    chk("t1_irq_n0", 32'(EVT_IRQ), 0);
    tick();
    chk("t1_irq_n1", 32'(EVT_IRQ), 1);
    tick();
    chk("t1_irq_n2", 32'(EVT_IRQ), 0);
    ack_one("t1_data");
    chk("t1_valid_after", 32'(EVT_VALID), 0);
    chk_count("t1_count_after");
    tick();
    chk("t1_idle_irq", 32'(EVT_IRQ), 0);

    // ack while empty is ignored
    EVT_ACK = 1'b1;
    tick();
    EVT_ACK = 1'b0;
    chk_count("empty_ack_count");

    // same-cycle encoder + key
    CODE_INT = 1'b1; CODE_DATA = 8'hA1; sb.push_back(8'hA1);
    KEY_INT  = 1'b1; KEY_DATA  = 8'h83; sb.push_back(8'h83);
    tick();
    CODE_INT = 1'b0; KEY_INT = 1'b0;
    chk_count("t2_count");
    tick();
    chk("t2_irq1", 32'(EVT_IRQ), 1);
    tick();
    ack_one("t2_data_a1");
    chk("t2_irq2", 32'(EVT_IRQ), 1);
    tick();
    ack_one("t2_data_83");
    chk_count("t2_count_end");

    // fill, overflow, ack+strobe while full, clear
    for (int i = 0; i < 8; i++) key(8'h10 + 8'(i), 1'b1);
    chk_count("t3_full");
    key(8'h7F, 1'b0);
    chk_count("t3_drop_count");
    chk("t3_ovf", 32'(OVERFLOW), 1);
    chk("t3_ack_head", 32'(EVT_DATA), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(8'h20);
    EVT_ACK = 1'b1; KEY_INT = 1'b1; KEY_DATA = 8'h20;
    tick();
    EVT_ACK = 1'b0; KEY_INT = 1'b0;
    chk_count("t3_ack_push_count");
    chk("t3_ovf_hold", 32'(OVERFLOW), 1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    chk("t3_ovf_clr", 32'(OVERFLOW), 0);
    OVF_CLR = 1'b1; KEY_INT = 1'b1; KEY_DATA = 8'h7E;
    tick();
    OVF_CLR = 1'b0; KEY_INT = 1'b0;
    chk("t3_set_wins", 32'(OVERFLOW), 1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    for (int i = 0; i < 8; i++) ack_one("t3_drain");
    chk_count("t3_empty");

    // one free slot, both strobes: encoder kept, key dropped
    for (int i = 0; i < 7; i++) key(8'h30 + 8'(i), 1'b1);
    chk_count("t4_seven");
    CODE_INT = 1'b1; CODE_DATA = 8'hB2; sb.push_back(8'hB2);
    KEY_INT  = 1'b1; KEY_DATA  = 8'h46;
    tick();
    CODE_INT = 1'b0; KEY_INT = 1'b0;
    chk_count("t4_count");
    chk("t4_ovf", 32'(OVERFLOW), 1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    for (int i = 0; i < 8; i++) ack_one("t4_drain");
    chk_count("t4_empty");
    repeat (5) tick();

`ifdef KEY_REPEAT_EN
    key(8'h45, 1'b1);
    repeat (499) tick();
    chk_count("rep_before_first");
    tick();
    sb.push_back(8'hC5);
    chk_count("rep_first");
    repeat (99) tick();
    chk_count("rep_before_second");
    tick();
    sb.push_back(8'hC5);
    chk_count("rep_second");
    key(8'h85, 1'b1);
    repeat (700) tick();
    chk_count("rep_stopped");
    for (int i = 0; i < 4; i++) ack_one("rep_drain");
    repeat (5) tick();
`endif

    // IRQ retry without ack
    key(8'h05, 1'b1);
    chk("t5_irq_n0", 32'(EVT_IRQ), 0);
    tick();
    chk("t5_irq_n1", 32'(EVT_IRQ), 1);
    tick();
    chk("t5_irq_n2", 32'(EVT_IRQ), 0);
    seen = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (EVT_IRQ) begin
        seen = i;
        break;
      end
    end
    chk("t5_retry_gap", 32'(seen), 1000);

    // asynchronous reset mid-operation
    RST = 1'b0;
    #1;
    sb.delete();
    chk("t6_irq",   32'(EVT_IRQ),   0);
    chk_count("t6_count");
    chk("t6_valid", 32'(EVT_VALID), 0);
    chk("t6_data",  32'(EVT_DATA),  0);
    #2;
    RST = 1'b1;
    tick();
    chk_count("t6_count_after");
    chk("t6_irq_after", 32'(EVT_IRQ), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Buffers key and encoder events from the keyboard front end in a small FIFO and serves them to the host MCU with an interrupt/acknowledge handshake. Key and encoder strobes may arrive in the same cycle, and both events are kept. It sits between the keyboard scan and encoder decoders and the host bus interface, in the `CLK_LOW` domain. Optionally, it generates typematic auto-repeat events for a held key.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, 2..64.
- `IRQ_RETRY`, 1000, `CLK_LOW` cycles in WAIT without ack before IRQ is re-pulsed.
- `REPEAT_DLY`, 500, cycles from press to first repeat (used only with the macro).
- `REPEAT_PER`, 100, cycles between subsequent repeats (used only with the macro).
- `CLK_LOW` in 1: the single clock; all logic on posedge.
- `RST` in 1: asynchronous, active-low reset.
- `KEY_INT` in 1: one-cycle key event strobe.
- `KEY_DATA` in 8: {sta[1:0], code[5:0]}; sta 2'b01 = press, 2'b10 = release.
- `CODE_INT` in 1: one-cycle encoder event strobe.
- `CODE_DATA` in 8: encoder value, stored verbatim.
- `EVT_VALID` out 1: FIFO non-empty; `EVT_DATA` holds the head entry.
- `EVT_DATA` out 8: head entry.
- `EVT_ACK` in 1: pops the head entry when `EVT_VALID` = 1.
- `EVT_IRQ` out 1: one-cycle interrupt pulse to the host.
- `EVT_COUNT` out clog2(DEPTH)+1: current number of stored entries.
- `OVERFLOW` out 1: sticky flag, set when any event is dropped.
- `OVF_CLR` in 1: clears `OVERFLOW`.

## Operation
- Reset values: `EVT_VALID` 0, `EVT_DATA` 8'h00, `EVT_IRQ` 0, `EVT_COUNT` 0, `OVERFLOW` 0; pointers 0; FSM in IDLE.
- Ingress order within one cycle: encoder first, then key, then repeat (macro only). Up to 2 writes per cycle.
- Pop before push: an ack in a cycle frees its slot for writes in that same cycle. `EVT_COUNT` = old + writes − pop.
- Drop rule: an event that finds no free slot is dropped and `OVERFLOW` is set. With one free slot and both strobes, the encoder event is stored and the key event is dropped.
- `OVF_CLR` together with a new drop in the same cycle leaves `OVERFLOW` = 1 (set wins).
- `EVT_ACK` while empty is ignored; no pointer change.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full = count == DEPTH.
- IRQ FSM:
  - IDLE: when count > 0, go to NOTIFY.
  - NOTIFY: `EVT_IRQ` = 1 for exactly one cycle, then go to WAIT.
  - WAIT: on a valid ack, go to NOTIFY if post-pop count > 0, else IDLE.
  - WAIT: if the retry counter reaches `IRQ_RETRY` with no ack, go to NOTIFY.
  - The retry counter clears on entry to WAIT.
- Reset mid-operation: all entries are discarded immediately and outputs take their reset values asynchronously.

## Timing
- Strobe at edge N: entry stored at N; `EVT_VALID`/`EVT_DATA`/`EVT_COUNT` updated after N. If the FIFO was empty, `EVT_IRQ` is high in cycle N+2 (IDLE→NOTIFY at N+1).
- Ack at edge M: the next head is visible after M.
- `EVT_DATA` is combinational from the registered array at the read pointer. It is 8'h00 after reset, and otherwise holds the stale value when empty.

## Configuration
- Macro `KEY_REPEAT_EN`.
- Defined:
  - A stored press (sta 01) arms the repeat counter and latches its code; a release or a new press re-latches or disarms it.
  - After `REPEAT_DLY` cycles, and then every `REPEAT_PER` cycles, the block injects {2'b11, code}.
  - A repeat that collides with an external strobe waits one cycle; the counter holds meanwhile.
  - If the FIFO is full, the repeat is dropped, `OVERFLOW` is set, and the period restarts.
  - A release whose code does not match the latched code has no effect on the repeat state.
- Undefined: no repeat logic is built, and sta 2'b11 is never generated by this block.

## Test plan
- Reset, then `KEY_INT` with 8'h45 → `EVT_IRQ` pulse 2 cycles later, `EVT_DATA` 8'h45, `EVT_COUNT` 1. Ack → `EVT_VALID` 0, FSM back in IDLE.
- Same-cycle `CODE_INT` 8'hA1 and `KEY_INT` 8'h83 → reads return A1 then 83, count 2, a second IRQ after the first ack.
- Fill to 8 entries, then one extra strobe → entry dropped, `OVERFLOW` 1. Ack plus strobe in the same cycle → stored, count stays 8. `OVF_CLR` → 0.
- With 7 entries, both strobes in one cycle → encoder stored, key dropped, `OVERFLOW` 1.
- Hold off ack for `IRQ_RETRY` cycles → a second IRQ pulse. Assert `RST` low mid-sequence → count 0 and IRQ 0 immediately.
- With `KEY_REPEAT_EN`, press 8'h45 and wait → 8'hC5 at +500 and +600 cycles. Release 8'h85 → no further repeats.
